// File: rtl/mux_operand_sequencer.sv
// Operand sequencer in front of a 4:1 word mux: gathers four words, then walks
// the select 0..3 for REPEAT passes before returning to collect the next group.
module mux_operand_sequencer #(
    parameter int N      = 32,
    parameter int REPEAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [1:0]   out_sel,
    output logic [N-1:0] out_d0,
    output logic [N-1:0] out_d1,
    output logic [N-1:0] out_d2,
    output logic [N-1:0] out_d3,
    output logic [7:0]   pass_cnt
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [7:0] LAST_PASS = 8'(REPEAT - 1);

    state_t         state_q, state_d;
    logic [1:0]     wr_idx_q, wr_idx_d;
    logic [1:0]     sel_q, sel_d;
    logic [7:0]     pass_q, pass_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   slot_q [4];
    logic [N-1:0]   slot_d [4];

    logic           in_ready_s;
    logic           in_hs_s;
    logic           out_hs_s;
    logic           last_out_s;

    // Handshake qualifiers; reset masks input acceptance in the same cycle.
    always_comb begin
        in_ready_s = (state_q == ST_LOAD) & ~rst;
        in_hs_s    = in_valid & in_ready_s;
        out_hs_s   = (state_q == ST_SCAN) & valid_q & out_ready;
        last_out_s = out_hs_s & (sel_q == 2'd3) & (pass_q == LAST_PASS);
    end

    // State register and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            wr_idx_q <= 2'd0;
            sel_q    <= 2'd0;
            pass_q   <= 8'd0;
            valid_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            sel_q    <= sel_d;
            pass_q   <= pass_d;
            valid_q  <= valid_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Next-state logic for the LOAD/SCAN controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (in_hs_s && (wr_idx_q == 2'd3)) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SCAN: begin
                if (last_out_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Counter and slot updates; slots are only written in LOAD so they stay
    // stable through SCAN and remain visible after returning to LOAD.
    always_comb begin
        wr_idx_d = wr_idx_q;
        sel_d    = sel_q;
        pass_d   = pass_q;
        valid_d  = valid_q;
        slot_d   = slot_q;
        case (state_q)
            ST_LOAD: begin
                if (in_hs_s) begin
                    slot_d[wr_idx_q] = in_data;
                    wr_idx_d         = wr_idx_q + 2'd1;
                    if (wr_idx_q == 2'd3) begin
                        valid_d = 1'b1;
                        sel_d   = 2'd0;
                        pass_d  = 8'd0;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else begin
                    wr_idx_d = wr_idx_q;
                end
            end
            ST_SCAN: begin
                if (!out_hs_s) begin
                    sel_d = sel_q;
                end else if (sel_q != 2'd3) begin
                    sel_d = sel_q + 2'd1;
                end else if (pass_q != LAST_PASS) begin
                    sel_d  = 2'd0;
                    pass_d = pass_q + 8'd1;
                end else begin
                    sel_d   = 2'd0;
                    pass_d  = 8'd0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Outputs: in_ready is the only combinational one, the rest are register copies.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = valid_q;
        out_sel   = sel_q;
        pass_cnt  = pass_q;
        out_d0    = slot_q[0];
        out_d1    = slot_q[1];
        out_d2    = slot_q[2];
        out_d3    = slot_q[3];
    end

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// Scoreboard bench: two instances (REPEAT=1 and REPEAT=3) sharing one driver,
// selected by use_b; every output handshake is checked against a queued expectation.
module tb_mux_operand_sequencer;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         out_ready;
    logic         use_b;

    logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [1:0] a_sel, b_sel;
    logic [7:0] a_pass, b_pass;
    logic [N-1:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;

    always #5 clk = ~clk;

    mux_operand_sequencer #(.N(N), .REPEAT(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~use_b), .in_data(in_data),
        .in_ready(a_in_ready), .out_ready(out_ready & ~use_b), .out_valid(a_out_valid),
        .out_sel(a_sel), .out_d0(a_d0), .out_d1(a_d1), .out_d2(a_d2), .out_d3(a_d3),
        .pass_cnt(a_pass)
    );

    mux_operand_sequencer #(.N(N), .REPEAT(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid & use_b), .in_data(in_data),
        .in_ready(b_in_ready), .out_ready(out_ready & use_b), .out_valid(b_out_valid),
        .out_sel(b_sel), .out_d0(b_d0), .out_d1(b_d1), .out_d2(b_d2), .out_d3(b_d3),
        .pass_cnt(b_pass)
    );

    wire         m_in_ready  = use_b ? b_in_ready  : a_in_ready;
    wire         m_out_valid = use_b ? b_out_valid : a_out_valid;
    wire [1:0]   m_sel       = use_b ? b_sel  : a_sel;
    wire [7:0]   m_pass      = use_b ? b_pass : a_pass;
    wire [N-1:0] m_d0        = use_b ? b_d0 : a_d0;
    wire [N-1:0] m_d1        = use_b ? b_d1 : a_d1;
    wire [N-1:0] m_d2        = use_b ? b_d2 : a_d2;
    wire [N-1:0] m_d3        = use_b ? b_d3 : a_d3;

    typedef struct packed {
        logic [1:0]   sel;
        logic [7:0]   pass;
        logic [N-1:0] d0;
        logic [N-1:0] d1;
        logic [N-1:0] d2;
        logic [N-1:0] d3;
    } exp_t;

    exp_t         sb_q [$];
    exp_t         mon_e;
    logic [N-1:0] m_slot [4];
    int           m_wr;
    int           errors = 0;
    int           checks = 0;

    task automatic check_val(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_wr = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
    endtask

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send_word(input logic [N-1:0] d);
        int rep;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        for (int i = 0; i < 60 && !m_in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        if (!m_in_ready) begin
            check_val("in_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            m_slot[m_wr] = d;
            if (m_wr == 3) begin
                rep = use_b ? 3 : 1;
                for (int p = 0; p < rep; p++) begin
                    for (int s = 0; s < 4; s++) begin
                        e.sel  = 2'(s);
                        e.pass = 8'(p);
                        e.d0   = m_slot[0];
                        e.d1   = m_slot[1];
                        e.d2   = m_slot[2];
                        e.d3   = m_slot[3];
                        sb_q.push_back(e);
                    end
                end
                m_wr = 0;
            end else begin
                m_wr = m_wr + 1;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Drain the current scan and wait (bounded) for the block to accept input again.
    task automatic wait_load();
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 60 && !m_in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        check_val("load_wait", 32'(m_in_ready), 32'd1);
    endtask

    // Scoreboard monitor: each output handshake pops one expectation.
    always begin
        @(negedge clk);
        #1;
        if (!rst && m_out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("sb_sel", 32'(m_sel), 32'(mon_e.sel));
                check_val("sb_pass", 32'(m_pass), 32'(mon_e.pass));
                check_val("sb_d0", m_d0, mon_e.d0);
                check_val("sb_d1", m_d1, mon_e.d1);
                check_val("sb_d2", m_d2, mon_e.d2);
                check_val("sb_d3", m_d3, mon_e.d3);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        use_b = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_in_ready", 32'(m_in_ready), 32'd1);
        check_val("rst_out_valid", 32'(m_out_valid), 32'd0);
        check_val("rst_sel", 32'(m_sel), 32'd0);
        check_val("rst_pass", 32'(m_pass), 32'd0);
        check_val("rst_d0", m_d0, 32'd0);
        check_val("rst_d3", m_d3, 32'd0);
        @(negedge clk);

        // Basic flow, out_ready held high.
        out_ready = 1'b1;
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        #1;
        check_val("lat_valid", 32'(m_out_valid), 32'd1);
        check_val("lat_sel", 32'(m_sel), 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_val("basic_sel", 32'(m_sel), 32'(i));
            check_val("basic_in_ready", 32'(m_in_ready), 32'd0);
        end
        @(negedge clk);
        #1;
        check_val("ret_in_ready", 32'(m_in_ready), 32'd1);
        check_val("ret_out_valid", 32'(m_out_valid), 32'd0);
        check_val("ret_keep_d2", m_d2, 32'h33333333);

        // Backpressure at out_sel=2.
        @(negedge clk);
        out_ready = 1'b0;
        send_word(32'hA0000001);
        send_word(32'hA0000002);
        send_word(32'hA0000003);
        send_word(32'hA0000004);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("bp_sel", 32'(m_sel), 32'd2);
            check_val("bp_valid", 32'(m_out_valid), 32'd1);
            check_val("bp_in_ready", 32'(m_in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check_val("bp_release_sel", 32'(m_sel), 32'd3);
        wait_load();

        // Input gaps, then an ignored word during SCAN.
        @(negedge clk);
        out_ready = 1'b0;
        send_word(32'h0000C001);
        send_word(32'h0000C002);
        repeat (3) @(negedge clk);
        send_word(32'h0000C003);
        send_word(32'h0000C004);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_val("ign_in_ready", 32'(m_in_ready), 32'd0);
            check_val("ign_d0", m_d0, 32'h0000C001);
            check_val("ign_d1", m_d1, 32'h0000C002);
            check_val("ign_d2", m_d2, 32'h0000C003);
            check_val("ign_d3", m_d3, 32'h0000C004);
        end
        in_valid = 1'b0;
        wait_load();

        // Reset after two words discards the partial group.
        @(negedge clk);
        out_ready = 1'b0;
        send_word(32'hBAD00001);
        send_word(32'hBAD00002);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_word(32'h5A5A0001);
        send_word(32'h5A5A0002);
        send_word(32'h5A5A0003);
        send_word(32'h5A5A0004);
        #1;
        check_val("mrst_d0", m_d0, 32'h5A5A0001);
        check_val("mrst_d3", m_d3, 32'h5A5A0004);
        wait_load();

        // Reset mid-SCAN at out_sel=1.
        @(negedge clk);
        out_ready = 1'b0;
        send_word(32'h77770001);
        send_word(32'h77770002);
        send_word(32'h77770003);
        send_word(32'h77770004);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check_val("srst_sel_pre", 32'(m_sel), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_val("srst_in_ready_rst", 32'(m_in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("srst_valid", 32'(m_out_valid), 32'd0);
        check_val("srst_in_ready", 32'(m_in_ready), 32'd1);
        check_val("srst_sel", 32'(m_sel), 32'd0);
        check_val("srst_d0", m_d0, 32'd0);

        // REPEAT=3 instance.
        @(negedge clk);
        use_b = 1'b1;
        out_ready = 1'b1;
        send_word(32'h0BB00001);
        send_word(32'h0BB00002);
        send_word(32'h0BB00003);
        send_word(32'h0BB00004);
        for (int k = 0; k < 12; k++) begin
            #1;
            check_val("r3_sel", 32'(m_sel), 32'(k % 4));
            check_val("r3_pass", 32'(m_pass), 32'(k / 4));
            check_val("r3_valid", 32'(m_out_valid), 32'd1);
            @(negedge clk);
        end
        #1;
        check_val("r3_in_ready", 32'(m_in_ready), 32'd1);
        check_val("r3_out_valid", 32'(m_out_valid), 32'd0);
        check_val("r3_pass_end", 32'(m_pass), 32'd0);

        repeat (2) @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_operand_sequencer.md
Name: mux_operand_sequencer

Overview:
- Upstream stage for the 4:1 word mux.
- Collects four N-bit operand words over a valid/ready input handshake and holds them on four parallel word outputs.
- Steps the 2-bit mux select through 0,1,2,3 using a valid/ready output handshake, for REPEAT passes.
- After the last pass it returns to collecting the next group of four.

Parameters:
- N, 32, operand word width.
- REPEAT, 1, number of full select passes (0..3) per loaded group. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word available on in_data.
- in_data  input  N  operand word.
- in_ready  output  1  block can accept a word this cycle.
- out_ready  input  1  downstream consumed current select this cycle.
- out_valid  output  1  out_sel and out_d0..out_d3 are valid.
- out_sel  output  2  select value for the 4:1 mux.
- out_d0  output  N  slot 0 word (mux input for select 0).
- out_d1  output  N  slot 1 word (mux input for select 1).
- out_d2  output  N  slot 2 word (mux input for select 2).
- out_d3  output  N  slot 3 word (mux input for select 3).
- pass_cnt  output  8  index of the current scan pass, 0-based.

Behaviour:
- States: LOAD and SCAN. Reset and power-up state is LOAD.
- Reset (rst high at clock edge):
  - state=LOAD, wr_idx=0, out_sel=0, pass_cnt=0, out_valid=0.
  - out_d0..out_d3 = 0.
  - Reset applies at any point, including mid-LOAD and mid-SCAN.
  - A partially loaded group is discarded.
- in_ready = (state==LOAD) & ~rst. This is the only combinational output; all others are registered.
- LOAD state:
  - An input handshake (in_valid & in_ready) writes in_data into slot wr_idx, then wr_idx increments.
  - A handshake with wr_idx==3 writes slot 3, wraps wr_idx to 0, and moves to SCAN.
  - On that same edge: out_valid=1, out_sel=0, pass_cnt=0.
  - Latency: out_valid is high the cycle after the 4th input handshake.
  - in_valid low holds all state. Input gaps are legal.
- SCAN state:
  - out_valid=1. out_d0..out_d3 are stable for the whole state.
  - out_ready low holds out_sel and all state.
  - An output handshake with out_sel<3 increments out_sel.
  - An output handshake with out_sel==3 and pass_cnt<REPEAT-1 sets out_sel=0 and increments pass_cnt.
  - An output handshake with out_sel==3 and pass_cnt==REPEAT-1 moves to LOAD with out_valid=0, out_sel=0, pass_cnt=0.
- Boundaries:
  - No input is accepted during SCAN. in_valid there is ignored and the upstream must hold its word.
  - out_ready with out_valid low has no effect.
  - Returning to LOAD keeps the old slot contents visible on out_d* until overwritten. Only out_valid qualifies them.
  - The earliest next input handshake is in the cycle after the final output handshake. There is no simultaneous LOAD/SCAN overlap.
  - rst wins over any handshake in the same cycle.
- Arithmetic: wr_idx and out_sel are 2-bit wrapping counters. pass_cnt is 8-bit and never exceeds REPEAT-1.
- Throughput: with both sides always ready, one group takes 4 + 4*REPEAT cycles.

Test Plan:
- Reset check: hold rst 2 cycles, then release -> in_ready=1, out_valid=0, out_sel=0, out_d0..d3=0, pass_cnt=0.
- Basic flow, REPEAT=1, out_ready=1:
  - Stimulus: send 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back.
  - Response: out_valid rises the cycle after the 4th word.
  - Response: out_sel reads 0,1,2,3 on consecutive cycles while out_d0..d3 hold the four words.
  - Response: in_ready returns to 1 the cycle after out_sel=3 is consumed.
- Backpressure: during SCAN hold out_ready=0 for 5 cycles at out_sel=2 -> out_sel stays 2, out_valid stays 1, in_ready stays 0; release -> out_sel goes to 3.
- Input gaps plus ignored input:
  - Stimulus: insert 3 idle cycles between words 2 and 3.
  - Response: slots fill in order.
  - Stimulus: assert in_valid with 0xDEADBEEF during SCAN.
  - Response: no write occurs; out_d0..d3 are unchanged.
- REPEAT=3: load four words with out_ready=1 -> out_sel cycles 0..3 three times, pass_cnt steps 0,1,2, then LOAD after 12 output handshakes.
- Mid-operation reset:
  - Stimulus: assert rst after 2 of 4 words.
  - Response: wr_idx resets and the next 4 words fill slots 0..3 from scratch.
  - Stimulus: assert rst mid-SCAN at out_sel=1.
  - Response: out_valid=0 and in_ready=1 the next cycle.
